// File: rtl/modexp_pkg.sv
// rtl/modexp_pkg.sv - shared state encoding and counter sizing for the modexp sequencer
package modexp_pkg;

    localparam int DEF_WIDTH = 1024;

    // Counters must hold every value 0..width inclusive
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_SQ_ISS  = 4'd2,
        ST_SQ_WAIT = 4'd3,
        ST_MU_ISS  = 4'd4,
        ST_MU_WAIT = 4'd5,
        ST_NEXT    = 4'd6,
        ST_PO_ISS  = 4'd7,
        ST_PO_WAIT = 4'd8,
        ST_FIN     = 4'd9
    } state_t;

endpackage

// File: rtl/modexp_lzd.sv
// rtl/modexp_lzd.sv - combinational priority encoder returning the highest set bit index
module modexp_lzd #(
    parameter int WIDTH = 1024,
    parameter int IDX_W = 11
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_zero
);

    // Scan upward so the highest set bit is the last one written
    always_comb begin
        o_idx  = '0;
        o_zero = ~|i_vec;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/modexp_seq.sv
// rtl/modexp_seq.sv - left-to-right Montgomery modexp sequencer; optional MODEXP_SKIP_LZ_EN skips leading exponent zeros
module modexp_seq
    import modexp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in_xm,
    input  logic [WIDTH-1:0] in_rm,
    input  logic [WIDTH-1:0] in_e,
    input  logic [WIDTH-1:0] in_m,
    output logic             mm_start,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic [WIDTH-1:0] mm_m,
    input  logic [WIDTH:0]   mm_result,
    input  logic             mm_done,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] mult_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_e;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_result;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_idx_load;
    logic             w_load_skip;
    logic             w_ebit;
    logic             w_mm_start;
    logic             w_unused_msb;

    // The multiplier guarantees a reduced result, so its extra top bit carries nothing
    assign w_unused_msb = mm_result[WIDTH];

    // Exponent bit under the current index; a shift keeps any index width legal
    assign w_ebit = |(r_e & (WIDTH'(1) << r_idx));

`ifdef MODEXP_SKIP_LZ_EN
    logic [CNT_W-1:0] w_lz_idx;
    logic             w_lz_zero;

    modexp_lzd #(
        .WIDTH (WIDTH),
        .IDX_W (CNT_W)
    ) u_lzd (
        .i_vec  (r_e),
        .o_idx  (w_lz_idx),
        .o_zero (w_lz_zero)
    );

    assign w_idx_load  = w_lz_idx;
    assign w_load_skip = w_lz_zero;
`else
    assign w_idx_load  = CNT_W'(WIDTH - 1);
    assign w_load_skip = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus multiplier handshake and operand steering
    always_comb begin
        w_state_nxt = r_state;
        w_mm_start  = 1'b0;
        mm_a        = '0;
        mm_b        = '0;
        mm_m        = '0;
        done        = 1'b0;
        busy        = 1'b1;

        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_state_nxt = w_load_skip ? ST_PO_ISS : ST_SQ_ISS;
            end
            ST_SQ_ISS: begin
                w_mm_start  = 1'b1;
                w_state_nxt = ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
                if (mm_done) begin
                    w_state_nxt = w_ebit ? ST_MU_ISS : ST_NEXT;
                end
            end
            ST_MU_ISS: begin
                w_mm_start  = 1'b1;
                w_state_nxt = ST_MU_WAIT;
            end
            ST_MU_WAIT: begin
                if (mm_done) begin
                    w_state_nxt = ST_NEXT;
                end
            end
            ST_NEXT: begin
                w_state_nxt = (r_idx == '0) ? ST_PO_ISS : ST_SQ_ISS;
            end
            ST_PO_ISS: begin
                w_mm_start  = 1'b1;
                w_state_nxt = ST_PO_WAIT;
            end
            ST_PO_WAIT: begin
                if (mm_done) begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_FIN: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (r_state != ST_IDLE) begin
            mm_m = r_m;
        end

        // Operands are held through the wait state so they stay stable until mm_done
        case (r_state)
            ST_SQ_ISS, ST_SQ_WAIT: begin
                mm_a = r_a;
                mm_b = r_a;
            end
            ST_MU_ISS, ST_MU_WAIT: begin
                mm_a = r_a;
                mm_b = r_x;
            end
            ST_PO_ISS, ST_PO_WAIT: begin
                mm_a = r_a;
                mm_b = WIDTH'(1);
            end
            default: begin
                mm_a = '0;
                mm_b = '0;
            end
        endcase
    end

    // Operand capture, accumulator, bit index, result and multiplication count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_x      <= '0;
            r_e      <= '0;
            r_m      <= '0;
            r_a      <= '0;
            r_result <= '0;
            r_idx    <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_mm_start) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_x   <= in_xm;
                        r_e   <= in_e;
                        r_m   <= in_m;
                        r_a   <= in_rm;
                        r_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    r_idx <= w_idx_load;
                end
                ST_SQ_WAIT, ST_MU_WAIT: begin
                    if (mm_done) begin
                        r_a <= mm_result[WIDTH-1:0];
                    end
                end
                ST_NEXT: begin
                    if (r_idx != '0) begin
                        r_idx <= r_idx - CNT_W'(1);
                    end
                end
                ST_PO_WAIT: begin
                    if (mm_done) begin
                        r_result <= mm_result[WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mm_start = w_mm_start;
    assign result   = r_result;
    assign mult_cnt = r_cnt;

endmodule

// File: tb/tb_modexp_seq.sv
// tb/tb_modexp_seq.sv - directed vector bench for modexp_seq with a 5-cycle Montgomery model (M=13, R=2^16)
module tb_modexp_seq;

    localparam int W = 16;
`ifdef MODEXP_SKIP_LZ_EN
    localparam bit LZ = 1'b1;
`else
    localparam bit LZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  in_xm, in_rm, in_e, in_m;
    logic          mm_start;
    logic [W-1:0]  mm_a, mm_b, mm_m;
    logic [W:0]    mm_result;
    logic          mm_done;
    logic [W-1:0]  result;
    logic          done, busy;
    logic [10:0]   mult_cnt;

    modexp_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_xm     (in_xm),
        .in_rm     (in_rm),
        .in_e      (in_e),
        .in_m      (in_m),
        .mm_start  (mm_start),
        .mm_a      (mm_a),
        .mm_b      (mm_b),
        .mm_m      (mm_m),
        .mm_result (mm_result),
        .mm_done   (mm_done),
        .result    (result),
        .done      (done),
        .busy      (busy),
        .mult_cnt  (mult_cnt)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           errors = 0;
    int           proto_err = 0;
    int           done_cnt = 0;
    int           mdl_cnt = 0;
    logic         mdl_done = 1'b0;
    logic [W:0]   mdl_res = '0;
    logic [W-1:0] cap_a = '0, cap_b = '0, cap_m = '0;
    logic         skip_stab = 1'b0;
    logic         stray_done = 1'b0;
    logic [W:0]   stray_res = '0;

    assign mm_done   = mdl_done | stray_done;
    assign mm_result = stray_done ? stray_res : mdl_res;

    // a*b*R^-1 mod 13, with R = 2^16 = 3 mod 13 and 3^-1 = 9 mod 13
    function automatic logic [W:0] mont(input logic [W-1:0] a, input logic [W-1:0] b);
        longint p;
        p = (longint'(a) * longint'(b)) % 13;
        return (W+1)'((p * 9) % 13);
    endfunction

    always @(posedge clk) begin
        mdl_done <= 1'b0;
        if (done) done_cnt <= done_cnt + 1;
        if (reset) skip_stab <= 1'b1;
        if (mdl_cnt > 0) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                mdl_done <= 1'b1;
                mdl_res  <= mont(cap_a, cap_b);
            end
            if (!skip_stab && !reset && (mm_a != cap_a || mm_b != cap_b || mm_m != cap_m))
                proto_err <= proto_err + 1;
        end
        if (mm_start) begin
            if (mdl_cnt > 0 || mdl_done) proto_err <= proto_err + 1;
            cap_a     <= mm_a;
            cap_b     <= mm_b;
            cap_m     <= mm_m;
            mdl_cnt   <= 5;
            skip_stab <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_run(input logic [W-1:0] xm, input logic [W-1:0] e);
        in_xm = xm;
        in_rm = 16'd3;
        in_e  = e;
        in_m  = 16'd13;
        start = 1'b1;
        tick();
        start = 1'b0;
        in_xm = 16'hFFFF;
        in_rm = 16'h0000;
        in_e  = 16'hAAAA;
        in_m  = 16'd7;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 2000) begin
            tick();
            n++;
        end
        chk({name, " timeout"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        logic [W-1:0] xm;
        logic [W-1:0] e;
        int           res;
        int           cnt_full;
        int           cnt_lz;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int d0;
        int n;
        int cnt_e5;

        vecs[0] = '{xm: 16'd9,  e: 16'd5,      res: 9, cnt_full: 19, cnt_lz: 6};
        vecs[1] = '{xm: 16'd9,  e: 16'd0,      res: 1, cnt_full: 17, cnt_lz: 1};
        vecs[2] = '{xm: 16'd6,  e: 16'd11,     res: 7, cnt_full: 20, cnt_lz: 8};
        vecs[3] = '{xm: 16'd2,  e: 16'd3,      res: 8, cnt_full: 19, cnt_lz: 5};
        vecs[4] = '{xm: 16'd10, e: 16'd2,      res: 1, cnt_full: 18, cnt_lz: 4};
        vecs[5] = '{xm: 16'd6,  e: 16'hFFFF,   res: 8, cnt_full: 33, cnt_lz: 33};
        vecs[6] = '{xm: 16'd8,  e: 16'd1,      res: 7, cnt_full: 18, cnt_lz: 3};
        vecs[7] = '{xm: 16'd6,  e: 16'h8000,   res: 9, cnt_full: 18, cnt_lz: 18};
        cnt_e5 = LZ ? 6 : 19;

        reset = 1'b1;
        start = 1'b0;
        in_xm = '0;
        in_rm = '0;
        in_e  = '0;
        in_m  = '0;
        repeat (3) tick();
        chk("reset busy",     64'(busy),     64'd0);
        chk("reset done",     64'(done),     64'd0);
        chk("reset result",   64'(result),   64'd0);
        chk("reset mult_cnt", 64'(mult_cnt), 64'd0);
        chk("reset mm_start", 64'(mm_start), 64'd0);
        chk("reset mm_m",     64'(mm_m),     64'd0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            d0 = done_cnt;
            start_run(vecs[i].xm, vecs[i].e);
            if (i == 0) chk("start after reset busy", 64'(busy), 64'd1);
            wait_idle($sformatf("vec%0d", i));
            chk($sformatf("vec%0d result", i), 64'(result), 64'(vecs[i].res));
            chk($sformatf("vec%0d mult_cnt", i), 64'(mult_cnt),
                64'(LZ ? vecs[i].cnt_lz : vecs[i].cnt_full));
            chk($sformatf("vec%0d done pulses", i), 64'(done_cnt - d0), 64'd1);
        end

        // Second start during SQ_WAIT and a stray mm_done in IDLE
        d0 = done_cnt;
        start_run(16'd9, 16'd5);
        n = 0;
        while (!mm_start && n < 100) begin
            tick();
            n++;
        end
        chk("ignore first issue seen", 64'(mm_start), 64'd1);
        tick();
        in_xm = 16'd6;
        in_e  = 16'd11;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle("ignore run");
        chk("ignore result",   64'(result),         64'd9);
        chk("ignore mult_cnt", 64'(mult_cnt),       64'(cnt_e5));
        chk("ignore done",     64'(done_cnt - d0),  64'd1);
        stray_res  = 17'd5;
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (3) tick();
        chk("stray result",   64'(result),        64'd9);
        chk("stray mult_cnt", 64'(mult_cnt),      64'(cnt_e5));
        chk("stray busy",     64'(busy),          64'd0);
        chk("stray done",     64'(done_cnt - d0), 64'd1);

        // Reset in MU_WAIT, late mm_done afterwards
        start_run(16'd9, 16'd5);
        n = 0;
        while (!(mm_start && mm_b == 16'd9) && n < 400) begin
            tick();
            n++;
        end
        chk("reset mid mu issue seen", 64'(mm_start && mm_b == 16'd9), 64'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        d0 = done_cnt;
        repeat (8) tick();
        chk("midreset busy",     64'(busy),          64'd0);
        chk("midreset done",     64'(done_cnt - d0), 64'd0);
        chk("midreset result",   64'(result),        64'd0);
        chk("midreset mult_cnt", 64'(mult_cnt),      64'd0);
        chk("midreset mm_start", 64'(mm_start),      64'd0);
        chk("midreset mm_a",     64'(mm_a),          64'd0);
        chk("midreset mm_b",     64'(mm_b),          64'd0);
        chk("midreset mm_m",     64'(mm_m),          64'd0);
        start_run(16'd6, 16'd11);
        wait_idle("post reset run");
        chk("post reset result",   64'(result),   64'd7);
        chk("post reset mult_cnt", 64'(mult_cnt), 64'(LZ ? 8 : 20));

        chk("protocol violations", 64'(proto_err), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
